// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks registers FIRST_REG..LAST_REG through an async
// register-file read port and streams {index, value} words over valid/ready.
module regfile_dump_reader #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  rf_ra,
  input  logic [31:0] rf_rd,
  output logic [31:0] out_data,
  output logic [4:0]  out_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  // Stream handshake: a word moves when out_valid && out_ready at a posedge;
  // while out_valid is high and out_ready is low, out_data/out_addr hold.
  typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

  localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
  localparam logic [4:0] LAST_A  = 5'(LAST_REG);

  state_t     state;
  logic [4:0] addr;

  // Registered address keeps the read port glitch-free.
  assign rf_ra = addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= FIRST_A;
      out_data  <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            addr  <= FIRST_A;
            busy  <= 1'b1;
            state <= READ;
          end
        end
        READ: begin
          out_data  <= rf_rd;
          out_addr  <= addr;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            // Termination on LAST_REG means addr never needs to wrap.
            if (addr == LAST_A) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              addr  <= addr + 5'd1;
              state <= READ;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
